// File: rtl/inval_coalesce_pkg.sv
// Shared constants and helpers for the invalidation-line coalescer.
package inval_coalesce_pkg;

    localparam int unsigned StatsCntWidth = 32;

    function automatic int unsigned line_offset_bits(input int unsigned line_width);
        return $clog2(line_width);
    endfunction

endpackage

// File: rtl/inval_cam_fifo.sv
// Depth-entry circular FIFO of line addresses with a parallel compare against all valid entries.
module inval_cam_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 60
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [Width-1:0]        push_line_i,
    input  logic                    pop_i,
    input  logic                    head_excl_i,
    input  logic [Width-1:0]        cmp_line_i,
    output logic                    match_o,
    output logic [Width-1:0]        head_line_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic             vld;
        logic [Width-1:0] line;
    } entry_t;

    entry_t          entries_q [Depth];
    entry_t          entries_d [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CntW'(Depth));
    assign count_o     = count_q;
    assign head_line_o = empty_o ? '0 : entries_q[rptr_q].line;

    // The head is left out of the compare when it is leaving this cycle.
    always_comb begin
        match_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (entries_q[i].vld && (entries_q[i].line == cmp_line_i) &&
                !(head_excl_i && (PtrW'(i) == rptr_q))) begin
                match_o = 1'b1;
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q + CntW'(push_i) - CntW'(pop_i);
        if (pop_i) begin
            entries_d[rptr_q].vld = 1'b0;
            rptr_d                = rptr_q + 1'b1;
        end
        if (push_i) begin
            entries_d[wptr_q] = '{vld: 1'b1, line: push_line_i};
            wptr_d            = wptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/inval_line_coalescer.sv
// Queues write invalidations as line addresses, merging duplicates already queued.
// Optional stats counters are enabled by defining INVAL_COALESCE_STATS_EN.
module inval_line_coalescer
    import inval_coalesce_pkg::*;
#(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [AddrWidth-1:0]    inval_addr_i,
    input  logic                    inval_valid_i,
    output logic                    inval_ready_o,
    output logic [AddrWidth-1:0]    inval_addr_o,
    output logic                    inval_valid_o,
    input  logic                    inval_ready_i,
    output logic [$clog2(Depth):0]  pending_o
`ifdef INVAL_COALESCE_STATS_EN
    ,
    output logic [StatsCntWidth-1:0] merged_cnt_o,
    output logic [StatsCntWidth-1:0] issued_cnt_o
`endif
);

    localparam int unsigned OffW  = line_offset_bits(L1LineWidth);
    localparam int unsigned LineW = AddrWidth - OffW;

    logic [LineW-1:0] in_line;
    logic [LineW-1:0] head_line;
    logic             match;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             unused_off;

    assign in_line    = inval_addr_i[AddrWidth-1:OffW];
    assign unused_off = ^inval_addr_i[OffW-1:0];

    assign inval_valid_o = !empty;
    assign inval_addr_o  = {head_line, {OffW{1'b0}}};
    assign pop           = inval_valid_o && inval_ready_i;
    assign inval_ready_o = !en_i || match || !full || pop;
    // Disabled requests are acknowledged and dropped; matches are absorbed.
    assign push          = inval_valid_i && inval_ready_o && en_i && !match;

    inval_cam_fifo #(
        .Depth (Depth),
        .Width (LineW)
    ) u_cam_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_line_i (in_line),
        .pop_i       (pop),
        .head_excl_i (pop),
        .cmp_line_i  (in_line),
        .match_o     (match),
        .head_line_o (head_line),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (pending_o)
    );

`ifdef INVAL_COALESCE_STATS_EN
    logic [StatsCntWidth-1:0] merged_cnt_q, merged_cnt_d;
    logic [StatsCntWidth-1:0] issued_cnt_q, issued_cnt_d;
    logic                     merge;

    assign merge        = inval_valid_i && en_i && match;
    assign merged_cnt_o = merged_cnt_q;
    assign issued_cnt_o = issued_cnt_q;

    always_comb begin
        merged_cnt_d = merged_cnt_q;
        issued_cnt_d = issued_cnt_q;
        if (merge && (merged_cnt_q != '1)) begin
            merged_cnt_d = merged_cnt_q + 1'b1;
        end
        if (pop && (issued_cnt_q != '1)) begin
            issued_cnt_d = issued_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            merged_cnt_q <= '0;
            issued_cnt_q <= '0;
        end else begin
            merged_cnt_q <= merged_cnt_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && full) |-> pop);
    a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (inval_valid_o && !inval_ready_i) |=> $stable(inval_addr_o));
    a_pending_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pending_o <= ($clog2(Depth) + 1)'(Depth));
`endif

endmodule

// File: tb/tb_inval_line_coalescer.sv
// Scoreboard bench for inval_line_coalescer: directed plan plus randomized traffic.
module tb_inval_line_coalescer;

    localparam int unsigned AW    = 64;
    localparam int unsigned LW_B  = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OFF   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b1;
    logic [AW-1:0] addr_i = '0;
    logic          vi = 1'b0;
    logic          rdy_o;
    logic [AW-1:0] addr_o;
    logic          vo;
    logic          rdy_i = 1'b0;
    logic [2:0]    pend;
`ifdef INVAL_COALESCE_STATS_EN
    logic [31:0]   merged_cnt;
    logic [31:0]   issued_cnt;
`endif

    inval_line_coalescer #(
        .AddrWidth   (AW),
        .L1LineWidth (LW_B),
        .Depth       (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en_i),
        .inval_addr_i  (addr_i),
        .inval_valid_i (vi),
        .inval_ready_o (rdy_o),
        .inval_addr_o  (addr_o),
        .inval_valid_o (vo),
        .inval_ready_i (rdy_i),
        .pending_o     (pend)
`ifdef INVAL_COALESCE_STATS_EN
        ,
        .merged_cnt_o  (merged_cnt),
        .issued_cnt_o  (issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an ordered list of distinct queued lines.
    logic [AW-1:0] mq[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] ln;
    int            n;
    bit            m_pop, m_match, m_ready;
    int            model_merges = 0;
    int            model_issues = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            model_merges = 0;
            model_issues = 0;
        end else begin
            n       = mq.size();
            ln      = addr_i >> OFF;
            m_pop   = (n != 0) && rdy_i;
            m_match = 1'b0;
            for (int i = (m_pop ? 1 : 0); i < n; i++) begin
                if (mq[i] == ln) m_match = 1'b1;
            end
            m_ready = !en_i || m_match || (n < DEPTH) || m_pop;
            chk("ready", {63'b0, rdy_o}, {63'b0, m_ready});
            chk("valid", {63'b0, vo}, {63'b0, n != 0});
            chk("pending", {61'b0, pend}, 64'(n));
            if (n == 0) chk("addr_idle", addr_o, 64'h0);
            if (m_pop) begin
                void'(mq.pop_front());
                model_issues++;
            end
            if (vi && en_i && m_match) model_merges++;
            if (vi && en_i && m_ready && !m_match) begin
                mq.push_back(ln);
                exp_q.push_back(ln << OFF);
            end
        end
    end

    // Monitor: every output handshake must deliver the oldest outstanding line.
    always @(negedge clk) begin
        if (rst_n && vo && rdy_i) begin
            if (exp_q.size() == 0) chk("unexpected_issue", addr_o, 64'hdead);
            else chk("issue_addr", addr_o, exp_q.pop_front());
        end
    end

    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic e, input logic r);
        vi = v;
        addr_i = a;
        en_i = e;
        rdy_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input logic r);
        for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b1, r);
    endtask

    initial begin
        #3;
        chk("rst_valid", {63'b0, vo}, 64'h0);
        chk("rst_pending", {61'b0, pend}, 64'h0);
        chk("rst_addr", addr_o, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(1'b1, 64'h8000_0014, 1'b1, 1'b1);
        chk("single_addr", addr_o, 64'h8000_0010);
        idle(3, 1'b1);

        cyc(1'b1, 64'h100, 1'b1, 1'b0);
        cyc(1'b1, 64'h108, 1'b1, 1'b0);
        cyc(1'b1, 64'h104, 1'b1, 1'b0);
        chk("merge_pending", {61'b0, pend}, 64'h1);
        idle(3, 1'b1);

        for (int i = 0; i < 4; i++) cyc(1'b1, 64'h1000 + 64'(i * 16), 1'b1, 1'b0);
        cyc(1'b1, 64'h1040, 1'b1, 1'b0);
        cyc(1'b1, 64'h1018, 1'b1, 1'b0);
        cyc(1'b1, 64'h1050, 1'b1, 1'b1);
        chk("full_pushpop", {61'b0, pend}, 64'h4);
        idle(6, 1'b1);

        cyc(1'b1, 64'h200, 1'b1, 1'b0);
        cyc(1'b1, 64'h200, 1'b1, 1'b1);
        idle(3, 1'b1);

        for (int i = 0; i < 3; i++) cyc(1'b1, 64'h3000 + 64'(i * 16), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'h3100 + 64'(i * 16), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'h3200 + 64'(i * 16), 1'b0, 1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                64'h8000_0000 + 64'($urandom_range(0, 7) << 4) + 64'($urandom_range(0, 15)),
                ($urandom_range(0, 9) != 0),
                $urandom_range(0, 1) == 1);
        end
        idle(8, 1'b1);

        for (int i = 0; i < 3; i++) cyc(1'b1, 64'h5000 + 64'(i * 16), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, vo}, 64'h0);
        chk("midrst_pending", {61'b0, pend}, 64'h0);
        chk("midrst_addr", addr_o, 64'h0);
        vi = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 64'h4444, 1'b1, 1'b0);
        chk("postrst_addr", addr_o, 64'h4440);
        idle(4, 1'b1);

`ifdef INVAL_COALESCE_STATS_EN
        chk("merged_cnt", 64'(merged_cnt), 64'(model_merges));
        chk("issued_cnt", 64'(issued_cnt), 64'(model_issues));
`endif
        chk("drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
